// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract, CHUNK bits per stage, valid/ready on both sides.
// Define PIPELINED_ADDER_SAT_EN to saturate the sum on signed overflow.
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int L = STAGES - 1;

    logic             adv;
    logic [STAGES-1:0] vld_pipe;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES-1];

    // Stage k adds chunk k. Pending operand chunks shrink by CHUNK bits per stage
    // and finished sum chunks grow, so the last stage sees a complete, aligned result.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SW = WIDTH - k * CHUNK;
        logic [SW-1:0]          src_a;
        logic [SW-1:0]          src_b;
        logic                   cin;
        logic [CHUNK:0]         add;
        logic [(k+1)*CHUNK-1:0] res;

        if (k == 0) begin : g_first
            assign src_a = a;
            assign src_b = sub ? ~b : b;
            assign cin   = sub;
            assign res   = add[CHUNK-1:0];
        end else begin : g_next
            assign src_a = g_stage[k-1].g_reg.a_q;
            assign src_b = g_stage[k-1].g_reg.b_q;
            assign cin   = g_stage[k-1].g_reg.c_q;
            assign res   = {add[CHUNK-1:0], g_stage[k-1].g_reg.s_q};
        end

        assign add = {1'b0, src_a[CHUNK-1:0]} + {1'b0, src_b[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, cin};

        if (k < STAGES - 1) begin : g_reg
            logic [SW-CHUNK-1:0]    a_q;
            logic [SW-CHUNK-1:0]    b_q;
            logic [(k+1)*CHUNK-1:0] s_q;
            logic                   c_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                end else if (adv) begin
                    a_q <= src_a[SW-1:CHUNK];
                    b_q <= src_b[SW-1:CHUNK];
                    s_q <= res;
                    c_q <= add[CHUNK];
                end
            end
        end
    end

    // Carry into the MSB recovered from the top bit of the last chunk.
    logic             msb_cin;
    logic             ovf_next;
    logic [WIDTH-1:0] sum_next;

    assign msb_cin  = g_stage[L].src_a[CHUNK-1] ^ g_stage[L].src_b[CHUNK-1]
                    ^ g_stage[L].add[CHUNK-1];
    assign ovf_next = msb_cin ^ g_stage[L].add[CHUNK];

`ifdef PIPELINED_ADDER_SAT_EN
    // On overflow both operand signs agree; A's sign picks the saturation rail.
    logic sign;
    assign sign     = g_stage[L].src_a[CHUNK-1];
    assign sum_next = ovf_next ? {sign, {(WIDTH-1){~sign}}} : g_stage[L].res;
`else
    assign sum_next = g_stage[L].res;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            sum      <= '0;
            c_out    <= 1'b0;
            ovf      <= 1'b0;
        end else if (adv) begin
            vld_pipe[0] <= in_valid;
            for (int i = 1; i < STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
            sum   <= sum_next;
            c_out <= g_stage[L].add[CHUNK];
            ovf   <= ovf_next;
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=16, CHUNK=4): vector table, stall stream, async reset.
module tb_pipelined_adder;
    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    pipelined_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a, b;
        logic        sub;
        logic [15:0] s_wrap, s_sat;
        logic        c, v;
    } vec_t;

    vec_t vecs[10];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_sum(input vec_t v);
`ifdef PIPELINED_ADDER_SAT_EN
        return v.s_sat;
`else
        return v.s_wrap;
`endif
    endfunction

    // Full-width reference: {sum, c_out, ovf}
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
        logic [15:0] yp;
        logic [16:0] f;
        logic        v;
        logic [15:0] r;
        yp = s ? ~y : y;
        f  = {1'b0, x} + {1'b0, yp} + {16'd0, s};
        v  = x[15] ^ yp[15] ^ f[15] ^ f[16];
        r  = f[15:0];
`ifdef PIPELINED_ADDER_SAT_EN
        if (v) r = {x[15], {15{~x[15]}}};
`endif
        return {r, f[16], v};
    endfunction

    task automatic run_vec(input int i);
        @(negedge clk);
        in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b; sub = vecs[i].sub; out_ready = 1'b1;
        #1 chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
        repeat (STAGES - 1) begin
            chk($sformatf("v%0d early out_valid", i), 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd1);
        chk($sformatf("v%0d sum", i), 32'(sum), 32'(exp_sum(vecs[i])));
        chk($sformatf("v%0d c_out", i), 32'(c_out), 32'(vecs[i].c));
        chk($sformatf("v%0d ovf", i), 32'(ovf), 32'(vecs[i].v));
        @(negedge clk);
        chk($sformatf("v%0d bubble out_valid", i), 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [17:0] exp_q[$];
        logic [17:0] held;
        logic [17:0] e;
        int sent, got;

        vecs[0] = '{16'h0003, 16'h0005, 1'b0, 16'h0008, 16'h0008, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
        vecs[5] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 16'h5555, 1'b0, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1};
        vecs[8] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 16'h1000, 1'b0, 1'b0};
        vecs[9] = '{16'hFFFF, 16'h0001, 1'b1, 16'hFFFE, 16'hFFFE, 1'b1, 1'b0};

        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset sum", 32'(sum), 32'd0);
        chk("reset c_out", 32'(c_out), 32'd0);
        chk("reset ovf", 32'(ovf), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(i);

        // Back-to-back stream with out_ready low for cycles 6..8
        sent = 0; got = 0; held = '0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc <= 8);
            if (sent < 8) begin
                in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, sub));
                sent++;
            end
            if (!out_ready && out_valid) begin
                chk($sformatf("stall in_ready c%0d", cyc), 32'(in_ready), 32'd0);
                if (cyc > 6) chk($sformatf("stall hold c%0d", cyc), 32'({sum, c_out, ovf}), 32'(held));
            end
            if (cyc == 6) held = {sum, c_out, ovf};
            if (out_valid && out_ready) begin
                chk($sformatf("stream pending r%0d", got), 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk($sformatf("stream result r%0d", got), 32'({sum, c_out, ovf}), 32'(e));
                end
                got++;
            end
        end
        in_valid = 1'b0;
        chk("stream sent", 32'(sent), 32'd8);
        chk("stream received", 32'(got), 32'd8);
        @(negedge clk);
        chk("stream drained", 32'(out_valid), 32'd0);

        // Async reset with three ops in flight
        out_ready = 1'b0;
        for (int j = 5; j < 8; j++) begin
            @(negedge clk);
            in_valid = 1'b1; a = vecs[j].a; b = vecs[j].b; sub = vecs[j].sub;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre-reset out_valid", 32'(out_valid), 32'd1);
        chk("pre-reset sum", 32'(sum), 32'(exp_sum(vecs[5])));
        #2 rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 32'(out_valid), 32'd0);
        chk("async reset sum", 32'(sum), 32'd0);
        chk("async reset c_out", 32'(c_out), 32'd0);
        chk("async reset ovf", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            chk($sformatf("post-reset no output n%0d", n), 32'(out_valid), 32'd0);
        end
        run_vec(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
